// File: rtl/mmc3_outer_bank_core.sv
// MMC3-class banking core: inner bank registers, multicart outer-bank latch,
// filtered A12 scanline counter and IRQ with selectable MMC3A/MMC3B behaviour.
module mmc3_outer_bank_core #(
  parameter int PRG_W    = 8,
  parameter int CHR_W    = 10,
  parameter int A12_FILT = 4,
  parameter int IRQ_REV  = 1
) (
  input  logic             m2,
  input  logic             map_rst,
  input  logic [14:0]      cpu_addr,
  input  logic [7:0]       cpu_dat,
  input  logic             wr_rom,
  input  logic             wr_wram,
  input  logic [2:0]       ppu_addr,
  output logic [PRG_W-1:0] prg_bank,
  output logic [CHR_W-1:0] chr_bank,
  output logic             mirror,
  output logic             ram_en,
  output logic             ram_wp,
  output logic             lock,
  output logic             irq
);

  logic [7:0]        r_q [8];
  logic [7:0]        r_d [8];
  logic [2:0]        select_q, select_d;
  logic              prg_mode_q, prg_mode_d;
  logic              chr_mode_q, chr_mode_d;
  logic              mirror_q, mirror_d;
  logic [1:0]        ram_prot_q, ram_prot_d;
  logic [7:0]        irq_latch_q, irq_latch_d;
  logic [7:0]        counter_q, counter_d;
  logic              reload_q, reload_d;
  logic              irq_en_q, irq_en_d;
  logic              irq_q, irq_d;
  logic [A12_FILT:0] hist_q, hist_d;
  logic [7:0]        x_q [4];
  logic [7:0]        x_d [4];
  logic [1:0]        idx_q, idx_d;

  logic [2:0] rsel;
  logic       a12_edge;
  logic       reload_path;
  logic       irq_set;
  logic [7:0] counter_step;
  logic [7:0] prg_inner;
  logic [7:0] chr_inner;
  logic [2:0] chr_slot;
  logic [7:0] cmask;
  logic       unused_ok;

  assign lock      = x_q[3][6];
  assign mirror    = mirror_q;
  assign ram_en    = ram_prot_q[1] & ~lock;
  assign ram_wp    = ram_prot_q[0];
  assign irq       = irq_q;
  assign unused_ok = ^{cpu_addr[12:1], x_q[3][7]};

  always_comb begin
    rsel         = {cpu_addr[14:13], cpu_addr[0]};
    // newest sample in bit 0; an edge needs A12_FILT lows before it
    a12_edge     = hist_q[0] & ~(|hist_q[A12_FILT:1]);
    hist_d       = {hist_q[A12_FILT-1:0], ppu_addr[2]};
    r_d          = r_q;
    select_d     = select_q;
    prg_mode_d   = prg_mode_q;
    chr_mode_d   = chr_mode_q;
    mirror_d     = mirror_q;
    ram_prot_d   = ram_prot_q;
    irq_latch_d  = irq_latch_q;
    counter_d    = counter_q;
    reload_d     = reload_q;
    irq_en_d     = irq_en_q;
    irq_d        = irq_q;
    x_d          = x_q;
    idx_d        = idx_q;
    irq_set      = 1'b0;
    reload_path  = (counter_q == 8'd0) || reload_q;
    counter_step = reload_path ? irq_latch_q : counter_q - 8'd1;

    if (a12_edge) begin
      counter_d = counter_step;
      if (reload_path) reload_d = 1'b0;
      if (IRQ_REV != 0) irq_set = (counter_step == 8'd0);
      else irq_set = (!reload_path && counter_q == 8'd1) ||
                     (reload_q && irq_latch_q == 8'd0);
    end

    // register writes land after the edge so a same-cycle write takes priority
    if (wr_rom) begin
      case (rsel)
        3'd0: begin
          select_d   = cpu_dat[2:0];
          prg_mode_d = cpu_dat[6];
          chr_mode_d = cpu_dat[7];
        end
        3'd1: begin
          if (select_q[2:1] == 2'b00) r_d[select_q] = {cpu_dat[7:1], 1'b0};
          else r_d[select_q] = cpu_dat;
        end
        3'd2: mirror_d    = cpu_dat[0];
        3'd3: ram_prot_d  = cpu_dat[7:6];
        3'd4: irq_latch_d = cpu_dat;
        3'd5: begin
          counter_d = 8'd0;
          reload_d  = 1'b1;
          irq_set   = 1'b0;
        end
        3'd6:    irq_en_d = 1'b0;
        default: irq_en_d = 1'b1;
      endcase
    end

    if (irq_set && irq_en_d) irq_d = 1'b1;
    if (wr_rom && rsel == 3'd6) irq_d = 1'b0;

    if (wr_wram && !lock) begin
      x_d[idx_q] = cpu_dat;
      idx_d      = idx_q + 2'd1;
    end
  end

  always_comb begin
    prg_inner = 8'hFF;
    case (cpu_addr[14:13])
      2'd0:    prg_inner = prg_mode_q ? 8'hFE : r_q[6];
      2'd1:    prg_inner = r_q[7];
      2'd2:    prg_inner = prg_mode_q ? r_q[6] : 8'hFE;
      default: prg_inner = 8'hFF;
    endcase
    prg_bank = PRG_W'((prg_inner & ~{2'b00, x_q[3][5:0]}) | x_q[1]);

    chr_slot = ppu_addr ^ {chr_mode_q, 2'b00};
    case (chr_slot[2:1])
      2'd0:    chr_inner = r_q[0] | {7'd0, chr_slot[0]};
      2'd1:    chr_inner = r_q[1] | {7'd0, chr_slot[0]};
      default: chr_inner = r_q[chr_slot - 3'd2];
    endcase
    cmask = x_q[2][3] ? (8'hFF >> (3'd7 - x_q[2][2:0])) : 8'h00;
    if (lock) chr_bank = CHR_W'({4'h0, (chr_inner & cmask) | x_q[0]} | {x_q[2][7:4], 8'h00});
    else chr_bank = CHR_W'(chr_inner);
  end

  always_ff @(posedge m2) begin
    if (map_rst) begin
      r_q[0]      <= 8'd0;
      r_q[1]      <= 8'd2;
      r_q[2]      <= 8'd4;
      r_q[3]      <= 8'd5;
      r_q[4]      <= 8'd6;
      r_q[5]      <= 8'd7;
      r_q[6]      <= 8'd0;
      r_q[7]      <= 8'd1;
      select_q    <= 3'd0;
      prg_mode_q  <= 1'b0;
      chr_mode_q  <= 1'b0;
      mirror_q    <= 1'b0;
      ram_prot_q  <= 2'd0;
      irq_latch_q <= 8'd0;
      counter_q   <= 8'd0;
      reload_q    <= 1'b0;
      irq_en_q    <= 1'b0;
      irq_q       <= 1'b0;
      hist_q      <= '1;
      x_q[0]      <= 8'd0;
      x_q[1]      <= 8'd0;
      x_q[2]      <= 8'd0;
      x_q[3]      <= 8'd0;
      idx_q       <= 2'd0;
    end else begin
      r_q         <= r_d;
      select_q    <= select_d;
      prg_mode_q  <= prg_mode_d;
      chr_mode_q  <= chr_mode_d;
      mirror_q    <= mirror_d;
      ram_prot_q  <= ram_prot_d;
      irq_latch_q <= irq_latch_d;
      counter_q   <= counter_d;
      reload_q    <= reload_d;
      irq_en_q    <= irq_en_d;
      irq_q       <= irq_d;
      hist_q      <= hist_d;
      x_q         <= x_d;
      idx_q       <= idx_d;
    end
  end

endmodule
